poly_compress_pipe: RTL and testbench

- Streaming, multi-lane Kyber coefficient compressor/decompressor.
- Per lane, per beat, it computes either Compress_q(x,d) = round(2^d·x/q) mod 2^d or Decompress_q(y,d) = round(q·y/2^d).
- The constant divider is replaced by reciprocal multiplication in a fixed 3-stage pipeline with valid/ready flow control.
- Sits between the polynomial RAM read path and the byte encoder (encryption ciphertext packing), and between the decoder and the NTT (decryption).

---
 rtl/poly_compress_pipe_pkg.sv | 25 ++
 rtl/poly_compress_pipe_comp_lane.sv | 94 +++++++++
 rtl/poly_compress_pipe.sv | 132 +++++++++++++
 tb/tb_poly_compress_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_compress_pipe_pkg.sv
// kyber_comp_pkg: shared constants and types for the Kyber coefficient
// compress/decompress pipeline.
//   KYBER_Q / KYBER_Q_HALF : modulus and its rounding offset floor(q/2)
//   RECIP_M / RECIP_SHIFT  : reciprocal multiplier ceil(2^36/q) and shift
//   D_MAX                  : largest supported compression depth
//   comp_mode_e            : per-beat operation select
package kyber_comp_pkg;

  localparam int unsigned KYBER_Q      = 3329;
  localparam int unsigned KYBER_Q_HALF = 1664;
  localparam int unsigned RECIP_M      = 20642679;
  localparam int unsigned RECIP_SHIFT  = 36;
  localparam int unsigned D_MAX        = 11;

  typedef enum logic {
    CMP_COMPRESS   = 1'b0,
    CMP_DECOMPRESS = 1'b1
  } comp_mode_e;

  // Depths outside 1..D_MAX produce an all-zero lane result.
  function automatic logic d_supported(input logic [3:0] d);
    return (d != 4'd0) && (d <= 4'(D_MAX));
  endfunction

endpackage

// File: rtl/poly_compress_pipe_comp_lane.sv
// comp_lane: one coefficient lane of the 3-stage compress/decompress datapath.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en                shared stage enable; all three stages shift together
//   coeff             low 12 bits of the lane input container
//   mode_s0, d_s0     mode/depth of the beat entering S1 (from the input)
//   mode_s1, d_s1     mode/depth of the beat currently held in S1
//   mode_s2, d_s2     mode/depth of the beat currently held in S2
//   result            S3 lane result, zero-extended to 16 bits
module comp_lane
  import kyber_comp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [11:0] coeff,
  input  comp_mode_e  mode_s0,
  input  logic [3:0]  d_s0,
  input  comp_mode_e  mode_s1,
  input  logic [3:0]  d_s1,
  input  comp_mode_e  mode_s2,
  input  logic [3:0]  d_s2,
  output logic [15:0] result
);

  logic [23:0] s1;
  logic [48:0] s2;

  logic [11:0] y_in;
  logic [23:0] n_next;
  logic [23:0] m_next;
  logic [48:0] prod_next;
  logic [48:0] rnd_next;
  logic [12:0] quot;
  logic [12:0] mask_d;
  logic [15:0] res_c;
  logic [15:0] res_d;

  // S1: compress forms (x << d) + floor(q/2); decompress forms y * q with
  // y masked to its low d bits. Both fit a shared 24-bit register.
  always_comb begin
    y_in   = coeff & ((12'd1 << d_s0) - 12'd1);
    n_next = ({12'd0, coeff} << d_s0) + 24'(KYBER_Q_HALF);
    m_next = 24'(y_in) * 24'(KYBER_Q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else if (en) begin
      s1 <= (mode_s0 == CMP_DECOMPRESS) ? m_next : n_next;
    end
  end

  // S2: compress multiplies by the reciprocal; decompress adds the
  // half-LSB rounding term 2^(d-1). Unsupported depths give garbage here
  // that S3 discards.
  always_comb begin
    prod_next = 49'(s1) * 49'(RECIP_M);
    rnd_next  = 49'(s1) + (49'd1 << (d_s1 - 4'd1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2 <= '0;
    end else if (en) begin
      s2 <= (mode_s1 == CMP_DECOMPRESS) ? rnd_next : prod_next;
    end
  end

  // S3: compress takes the quotient and wraps it mod 2^d; decompress
  // shifts the rounded product down by d.
  always_comb begin
    quot   = 13'(s2 >> RECIP_SHIFT);
    mask_d = (13'd1 << d_s2) - 13'd1;
    res_c  = 16'(quot & mask_d);
    res_d  = 16'(s2 >> d_s2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else if (en) begin
      if (!d_supported(d_s2)) begin
        result <= '0;
      end else if (mode_s2 == CMP_DECOMPRESS) begin
        result <= res_d;
      end else begin
        result <= res_c;
      end
    end
  end

endmodule

// File: rtl/poly_compress_pipe.sv
// poly_compress_pipe: streaming multi-lane Kyber Compress_q / Decompress_q
// with a fixed 3-stage pipeline and valid/ready flow control.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mode_i, d_i           per-beat mode (0 compress, 1 decompress) and depth
//   in_valid, in_ready    input handshake; in_ready is combinational
//   in_data, in_last      LANES x COEFF_W coefficients and end marker
//   out_valid, out_ready  output handshake
//   out_data, out_last    LANES x COEFF_W results and the beat's end marker
//   range_err             sticky compress-input range error
// Build option: POLY_COMPRESS_RANGE_CHK_EN enables the range check; when
// undefined range_err is tied to 0.
module poly_compress_pipe
  import kyber_comp_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int COEFF_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode_i,
  input  logic [3:0]               d_i,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*COEFF_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*COEFF_W-1:0] out_data,
  output logic                     out_last,
  output logic                     range_err
);

  logic       adv;
  comp_mode_e mode_in;
  logic       v1, v2, v3;
  logic       last1, last2, last3;
  comp_mode_e mode_s1, mode_s2;
  logic [3:0] d_s1, d_s2;
  logic       unused_hi;

  // Every stage moves when the output slot is empty or being drained;
  // bubbles travel with the data rather than being squeezed out.
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign mode_in   = comp_mode_e'(mode_i);
  assign out_valid = v3;
  assign out_last  = last3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      last1   <= 1'b0;
      last2   <= 1'b0;
      last3   <= 1'b0;
      mode_s1 <= CMP_COMPRESS;
      mode_s2 <= CMP_COMPRESS;
      d_s1    <= 4'd0;
      d_s2    <= 4'd0;
    end else if (adv) begin
      v1      <= in_valid;
      v2      <= v1;
      v3      <= v2;
      last1   <= in_last;
      last2   <= last1;
      last3   <= last2;
      mode_s1 <= mode_in;
      mode_s2 <= mode_s1;
      d_s1    <= d_i;
      d_s2    <= d_s1;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [15:0] lane_res;

    comp_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (adv),
      .coeff   (in_data[k*COEFF_W +: 12]),
      .mode_s0 (mode_in),
      .d_s0    (d_i),
      .mode_s1 (mode_s1),
      .d_s1    (d_s1),
      .mode_s2 (mode_s2),
      .d_s2    (d_s2),
      .result  (lane_res)
    );

    assign out_data[k*COEFF_W +: COEFF_W] = COEFF_W'(lane_res);
  end

  // Container bits above the 12-bit coefficient carry no information.
  always_comb begin
    unused_hi = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      unused_hi = unused_hi ^ (^in_data[k*COEFF_W+12 +: COEFF_W-12]);
    end
  end

`ifdef POLY_COMPRESS_RANGE_CHK_EN
  logic any_bad;
  logic range_err_q;

  // Only compress inputs must be reduced mod q; decompress inputs are
  // masked to d bits and can never be out of range.
  always_comb begin
    any_bad = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (in_data[k*COEFF_W +: 12] >= 12'(KYBER_Q)) begin
        any_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_err_q <= 1'b0;
    end else if (in_valid && adv && (mode_in == CMP_COMPRESS) && any_bad) begin
      range_err_q <= 1'b1;
    end
  end

  assign range_err = range_err_q;
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_poly_compress_pipe.sv
module tb_poly_compress_pipe;

  localparam int LANES   = 4;
  localparam int COEFF_W = 16;
  localparam int DW      = LANES * COEFF_W;
  localparam longint unsigned Q = 3329;

`ifdef POLY_COMPRESS_RANGE_CHK_EN
  localparam logic EXP_RANGE = 1'b1;
`else
  localparam logic EXP_RANGE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mode_i;
  logic [3:0]    d_i;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          range_err;

  poly_compress_pipe #(.LANES(LANES), .COEFF_W(COEFF_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_i    (mode_i),
    .d_i       (d_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    bit            chk_lat;
    int            exp_cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: round-half-up of the exact rational value.
  function automatic longint unsigned refCompress(input longint unsigned x, input int d);
    longint unsigned scale, r;
    if (d < 1 || d > 11) return 0;
    scale = 64'd1 << d;
    r = (2 * x * scale + Q) / (2 * Q);
    return r % scale;
  endfunction

  function automatic longint unsigned refDecompress(input longint unsigned yin, input int d);
    longint unsigned scale, y;
    if (d < 1 || d > 11) return 0;
    scale = 64'd1 << d;
    y = yin % scale;
    return (2 * Q * y + scale) / (2 * scale);
  endfunction

  function automatic logic [DW-1:0] modelBeat(input logic m, input int d, input logic [DW-1:0] data);
    logic [DW-1:0] res;
    longint unsigned x, r;
    res = '0;
    for (int k = 0; k < LANES; k++) begin
      x = longint'(data[k*COEFF_W +: 12]);
      r = m ? refDecompress(x, d) : refCompress(x, d);
      res[k*COEFF_W +: COEFF_W] = COEFF_W'(r);
    end
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one beat from a falling edge and hold it until it is accepted.
  task automatic applyStimulus(input logic m, input logic [3:0] d, input logic [DW-1:0] data,
                               input logic last, input bit lat);
    int   tries;
    bit   done;
    exp_t e;
    tries = 0;
    done  = 0;
    @(negedge clk);
    mode_i   = m;
    d_i      = d;
    in_data  = data;
    in_last  = last;
    in_valid = 1'b1;
    while (!done) begin
      #1;
      if (in_ready) begin
        e.data    = modelBeat(m, int'(d), data);
        e.last    = last;
        e.chk_lat = lat;
        e.exp_cyc = cyc + 3;
        sbq.push_back(e);
        done = 1;
      end else begin
        tries++;
        if (tries > 200) begin
          checks++;
          failures++;
          $display("[TB] FAIL in_ready_timeout actual=0 required=1");
          done = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checkOutput("drain_empty", DW'(sbq.size()), '0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("rst_out_valid", DW'(out_valid), '0);
    checkOutput("rst_out_last", DW'(out_last), '0);
    checkOutput("rst_range_err", DW'(range_err), '0);
    checkOutput("rst_out_data", out_data, '0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] pack4(input int a, input int b, input int c, input int e);
    logic [DW-1:0] v;
    v = '0;
    v[0*COEFF_W +: COEFF_W] = COEFF_W'(a);
    v[1*COEFF_W +: COEFF_W] = COEFF_W'(b);
    v[2*COEFF_W +: COEFF_W] = COEFF_W'(c);
    v[3*COEFF_W +: COEFF_W] = COEFF_W'(e);
    return v;
  endfunction

  function automatic logic [DW-1:0] randBeat();
    logic [DW-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*COEFF_W +: COEFF_W] = COEFF_W'($urandom_range(0, 65535));
    return v;
  endfunction

  // Monitor: decides deliveries between edges and compares against the queue.
  bit            held;
  logic [DW-1:0] held_data;
  logic          held_last;

  initial begin
    held = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 0;
      end else begin
        if (held) begin
          checkOutput("stall_out_valid", DW'(out_valid), DW'(1));
          checkOutput("stall_out_data", out_data, held_data);
          checkOutput("stall_out_last", DW'(out_last), DW'(held_last));
        end
        held = 0;
        if (out_valid && !out_ready) begin
          checkOutput("stall_in_ready", DW'(in_ready), '0);
          held      = 1;
          held_data = out_data;
          held_last = out_last;
        end
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_beat actual=%h required=none", out_data);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            checkOutput("out_data", out_data, e.data);
            checkOutput("out_last", DW'(out_last), DW'(e.last));
            if (e.chk_lat) checkOutput("latency", DW'(cyc), DW'(e.exp_cyc));
          end
        end
      end
    end
  end

  initial begin
    bit done_flag;
    rst_n     = 1'b0;
    mode_i    = 1'b0;
    d_i       = 4'd0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2;
    checkOutput("init_out_valid", DW'(out_valid), '0);
    checkOutput("init_out_data", out_data, '0);
    checkOutput("init_range_err", DW'(range_err), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, back-to-back, no stall, latency checked.
    applyStimulus(1'b0, 4'd1,  pack4(0, 1665, 3328, 832), 1'b0, 1);
    applyStimulus(1'b0, 4'd4,  pack4(1000, 1000, 7, 3000), 1'b0, 1);
    applyStimulus(1'b0, 4'd10, pack4(3328, 1, 2000, 100), 1'b1, 1);
    applyStimulus(1'b0, 4'd11, pack4(1, 3328, 1664, 1665), 1'b0, 1);
    applyStimulus(1'b1, 4'd4,  pack4(5, 15, 0, 8), 1'b0, 1);
    applyStimulus(1'b0, 4'd5,  pack4(10, 20, 30, 40), 1'b1, 1);
    applyStimulus(1'b1, 4'd1,  pack4(1, 0, 3, 2), 1'b0, 1);
    applyStimulus(1'b1, 4'd10, pack4(1023, 512, 1, 0), 1'b1, 1);
    applyStimulus(1'b1, 4'd0,  pack4(5, 6, 7, 8), 1'b0, 1);
    applyStimulus(1'b0, 4'd12, pack4(1000, 2000, 3000, 4), 1'b1, 1);
    idle();
    drain();

    // Backpressure: 8 beats with out_ready low for 5 cycles from cycle 4.
    fork
      begin
        for (int i = 0; i < 8; i++)
          applyStimulus(1'(i % 2), 4'(1 + i), randBeat(), 1'(i == 7), 0);
        idle();
      end
      begin
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Randomized mixed stream with random backpressure.
    done_flag = 0;
    fork
      begin
        for (int i = 0; i < 300; i++)
          applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 13)), randBeat(),
                        1'($urandom_range(0, 1)), 0);
        idle();
        done_flag = 1;
      end
      begin
        while (!done_flag) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with three beats in flight, then a fresh beat.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd4, pack4(4000, 3500, 10, 20), 1'b0, 0);
    idle();
    repeat (2) @(negedge clk);
    doReset();
    out_ready = 1'b1;
    applyStimulus(1'b0, 4'd4, pack4(1000, 0, 3328, 1665), 1'b1, 1);
    idle();
    drain();

    // Range error: decompress never flags, compress x=3329 flags sticky.
    applyStimulus(1'b1, 4'd11, pack4(4000, 3329, 4095, 0), 1'b0, 0);
    idle();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("range_decomp", DW'(range_err), '0);
    applyStimulus(1'b0, 4'd5, pack4(3329, 0, 0, 0), 1'b0, 0);
    checkOutput("range_before", DW'(range_err), '0);
    idle();
    #1;
    checkOutput("range_set", DW'(range_err), DW'(EXP_RANGE));
    drain();
    #1;
    checkOutput("range_sticky", DW'(range_err), DW'(EXP_RANGE));

    // Exhaustive compress sweep.
    for (int d = 1; d <= 11; d++) begin
      for (int x = 0; x < 4096; x += 4)
        applyStimulus(1'b0, 4'(d), pack4(x, x + 1, x + 2, x + 3), 1'(x == 4092), 0);
    end
    idle();
    drain();
    #1;
    checkOutput("range_final", DW'(range_err), DW'(EXP_RANGE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
